// File: rtl/edge_field_serializer.sv
// Record-to-field serializer: one wide record in, one field per beat out.
// Optional EDGE_FIELD_SERIALIZER_SKIP_ZERO_EN suppresses all-zero fields.
module edge_field_serializer #(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_W    = 8,
  parameter int TAG_W      = 4,
  parameter int MSB_FIRST  = 1,
  localparam int IDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W-1:0]            out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_last,
  output logic                          busy
);

  localparam int RW = NUM_FIELDS * FIELD_W;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_SEND = 4'd3;
  localparam logic [3:0] S_LAST = 4'd7;

  logic [3:0]       r_state;
  logic [3:0]       w_state_nx;
  logic [RW-1:0]    r_data;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;

  logic             w_in_acc;
  logic [IDX_W-1:0] w_ld_idx;
  logic             w_ld_last;
  logic [IDX_W-1:0] w_nx_idx;
  logic             w_nx_last;

  function automatic logic [FIELD_W-1:0] f_field(
    input logic [RW-1:0] rec,
    input int            i
  );
    int p;
    p = (MSB_FIRST != 0) ? (NUM_FIELDS - 1 - i) : i;
    return rec[p*FIELD_W +: FIELD_W];
  endfunction

`ifdef EDGE_FIELD_SERIALIZER_SKIP_ZERO_EN
  // {found, idx} of the first non-zero field at or after index s
  function automatic logic [IDX_W:0] f_next_nz(
    input logic [RW-1:0] rec,
    input int            s
  );
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (i >= s && f_field(rec, i) != '0)
        res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  logic [IDX_W:0] w_ld_a;
  logic [IDX_W:0] w_ld_b;
  logic [IDX_W:0] w_nx_a;
  logic [IDX_W:0] w_nx_b;

  always_comb begin
    w_ld_a    = f_next_nz(in_data, 0);
    w_ld_b    = f_next_nz(in_data,
                  int'(w_ld_a[IDX_W-1:0]) + 1);
    w_ld_idx  = w_ld_a[IDX_W] ? w_ld_a[IDX_W-1:0] : '0;
    w_ld_last = !w_ld_a[IDX_W] || !w_ld_b[IDX_W];
    w_nx_a    = f_next_nz(r_data, int'(r_idx) + 1);
    w_nx_b    = f_next_nz(r_data,
                  int'(w_nx_a[IDX_W-1:0]) + 1);
    w_nx_idx  = w_nx_a[IDX_W-1:0];
    w_nx_last = !w_nx_b[IDX_W];
  end
`else
  always_comb begin
    w_ld_idx  = '0;
    w_ld_last = (NUM_FIELDS == 1);
    w_nx_idx  = r_idx + 1'b1;
    w_nx_last = (int'(r_idx) + 1 == NUM_FIELDS - 1);
  end
`endif

  assign in_ready = rst_n &&
    (r_state == S_IDLE ||
     (out_valid && out_ready && out_last));
  assign w_in_acc = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_acc)
          w_state_nx = w_ld_last ? S_LAST : S_SEND;
      end
      S_SEND: begin
        if (out_ready)
          w_state_nx = w_nx_last ? S_LAST : S_SEND;
      end
      S_LAST: begin
        if (out_ready) begin
          if (w_in_acc)
            w_state_nx = w_ld_last ? S_LAST : S_SEND;
          else
            w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_tag  <= '0;
      r_idx  <= '0;
    end else if (w_in_acc) begin
      r_data <= in_data;
      r_tag  <= in_tag;
      r_idx  <= w_ld_idx;
    end else if (r_state == S_SEND && out_ready) begin
      r_idx  <= w_nx_idx;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_tag   = '0;
    out_last  = 1'b0;
    busy      = (r_state != S_IDLE);
    if (r_state == S_SEND || r_state == S_LAST) begin
      out_valid = 1'b1;
      out_data  = f_field(r_data, int'(r_idx));
      out_idx   = r_idx;
      out_tag   = r_tag;
      out_last  = (r_state == S_LAST);
    end
  end

endmodule

// File: tb/tb_edge_field_serializer.sv
// Directed bench for edge_field_serializer (default parameters).
// Skip-zero scenarios run when EDGE_FIELD_SERIALIZER_SKIP_ZERO_EN is set.
module tb_edge_field_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic [3:0]  out_tag;
  logic        out_last;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;

  // {valid, data, idx, tag, last, busy}
  logic [17:0] obs;
  logic [17:0] exp_v;

  edge_field_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, out_data, out_idx,
                out_tag, out_last, busy};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    in_tag    = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_run++;
      if ({in_ready, obs} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_c%0d got %h exp %h",
                 c, {in_ready, obs}, 19'd0);
      end
    end
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release got %b exp %b",
               {in_ready, out_valid, busy}, 3'b100);
    end
  endtask

  task automatic test_skip_zero();
    step();
    in_valid = 1'b1;
    in_data  = 64'h0000_AB00_0000_00CD;
    in_tag   = 4'h3;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    exp_v = {1'b1, 8'hAB, 3'd2, 4'h3, 1'b0, 1'b1};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL skip_b0 got %h exp %h", obs, exp_v);
    end
    step();
    @(negedge clk);
    exp_v = {1'b1, 8'hCD, 3'd7, 4'h3, 1'b1, 1'b1};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL skip_b1 got %h exp %h", obs, exp_v);
    end
    step();
    @(negedge clk);
    n_run++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL skip_idle got %b exp 00",
               {out_valid, busy});
    end
    in_valid = 1'b1;
    in_data  = 64'd0;
    in_tag   = 4'h6;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    exp_v = {1'b1, 8'h00, 3'd0, 4'h6, 1'b1, 1'b1};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL skip_zero_rec got %h exp %h",
               obs, exp_v);
    end
    step();
    @(negedge clk);
    n_run++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL skip_zero_end got %b exp 00",
               {out_valid, busy});
    end
  endtask

  task automatic test_basic();
    step();
    in_valid = 1'b1;
    in_data  = 64'h0011_2233_4455_6677;
    in_tag   = 4'h5;
    @(negedge clk);
    n_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_accept got %b exp 10",
               {in_ready, out_valid});
    end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = {1'b1, 8'(k * 17), 3'(k), 4'h5,
               (k == 7), 1'b1};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic_b%0d got %h exp %h",
                 k, obs, exp_v);
      end
      step();
    end
    @(negedge clk);
    n_run++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_end got %b exp 001",
               {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_backpressure();
    step();
    in_valid = 1'b1;
    in_data  = 64'h0011_2233_4455_6677;
    in_tag   = 4'h5;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = {1'b1, 8'(k * 17), 3'(k), 4'h5,
               (k == 7), 1'b1};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp_b%0d got %h exp %h",
                 k, obs, exp_v);
      end
      if (k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          step();
          @(negedge clk);
          exp_v = {1'b1, 8'h22, 3'd2, 4'h5,
                   1'b0, 1'b1};
          n_run++;
          if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bp_hold%0d got %h exp %h",
                     s, obs, exp_v);
          end
        end
        out_ready = 1'b1;
      end
      step();
    end
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end got %b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    step();
    in_valid = 1'b1;
    in_data  = 64'hA0A1_A2A3_A4A5_A6A7;
    in_tag   = 4'h1;
    step();
    in_data  = 64'hB0B1_B2B3_B4B5_B6B7;
    in_tag   = 4'h2;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      exp_v = {1'b1,
               (j < 8) ? 4'hA : 4'hB, 4'(j % 8),
               3'(j % 8),
               (j < 8) ? 4'h1 : 4'h2,
               (j % 8 == 7), 1'b1};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_b%0d got %h exp %h",
                 j, obs, exp_v);
      end
      if (j == 3 || j == 7) begin
        n_run++;
        if (in_ready !== (j == 7)) begin
          n_fail++;
          $display("FAIL b2b_rdy%0d got %b exp %b",
                   j, in_ready, (j == 7));
        end
      end
      step();
      if (j == 7) in_valid = 1'b0;
    end
    @(negedge clk);
    n_run++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end got %b exp 00",
               {out_valid, busy});
    end
  endtask

  task automatic test_mid_reset();
    step();
    in_valid = 1'b1;
    in_data  = 64'h0011_2233_4455_6677;
    in_tag   = 4'h5;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_v = {1'b1, 8'(k * 17), 3'(k), 4'h5,
               1'b0, 1'b1};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mrst_b%0d got %h exp %h",
                 k, obs, exp_v);
      end
      step();
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_run++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_rdy got %b exp 0", in_ready);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL mrst_idle got %b exp 001",
               {out_valid, busy, in_ready});
    end
    in_valid = 1'b1;
    in_data  = 64'hA0A1_A2A3_A4A5_A6A7;
    in_tag   = 4'h9;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = {1'b1, 4'hA, 4'(k), 3'(k), 4'h9,
               (k == 7), 1'b1};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mrst_new%0d got %h exp %h",
                 k, obs, exp_v);
      end
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset();
`ifdef EDGE_FIELD_SERIALIZER_SKIP_ZERO_EN
    test_skip_zero();
`else
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`endif
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_field_serializer.md
Name: edge_field_serializer

Overview:
- Generalised successor to the fixed 8-field, 8-bit wide record and the width-parameterised data+tag record.
- Accepts one packed record of NUM_FIELDS fields of FIELD_W bits, plus a TAG_W tag, over a valid/ready handshake.
- Emits the record one field per beat on a narrow valid/ready stream, each beat carrying field index, tag and last flag.
- Sits between wide register/config paths and narrow byte/word links; supports back-to-back records with no bubble.

Parameters:
- NUM_FIELDS, 8, fields per record (>=1).
- FIELD_W, 8, bits per field (>=1).
- TAG_W, 4, tag width carried unchanged to every output beat.
- MSB_FIRST, 1, 1: field 0 is the most-significant slice of in_data and is sent first; 0: field 0 is the least-significant slice.
- IDX_W (localparam), max(1, $clog2(NUM_FIELDS)), field index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  record valid.
- in_ready  out  1  record accepted when in_valid && in_ready.
- in_data  in  NUM_FIELDS*FIELD_W  packed record.
- in_tag  in  TAG_W  record tag.
- out_valid  out  1  beat valid.
- out_ready  in  1  beat accepted when out_valid && out_ready.
- out_data  out  FIELD_W  current field.
- out_idx  out  IDX_W  index of current field (0-based, in field order).
- out_tag  out  TAG_W  tag of the record being sent.
- out_last  out  1  high on the final beat of a record.
- busy  out  1  high while a record is held (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- FSM uses a 4-bit sparse encoding: IDLE=4'd0, SEND=4'd3, LAST=4'd7. Any other code returns to IDLE on the next clock.
- Reset (rst_n low at a clk edge): state=IDLE; out_valid=0, out_data=0, out_idx=0, out_tag=0, out_last=0, busy=0.
  - in_ready is forced 0 while rst_n is low; it is 1 from the first cycle after reset release.
  - Reset mid-record discards the record with no further beats.
- in_ready = rst_n && (state==IDLE || (out_valid && out_ready && out_last)). This is combinational from state and the output handshake.
- Accept: in_data and in_tag are captured into a shadow register. Next cycle out_valid=1 and out_idx=0, so latency is 1 cycle.
  - Next state is SEND, or LAST when NUM_FIELDS==1.
- SEND, beat accepted: out_idx increments. The state moves to LAST when the new index equals NUM_FIELDS-1.
- SEND or LAST, out_ready low: out_data, out_idx, out_tag and out_last hold stable and out_valid stays 1. No field is dropped or repeated.
- LAST: out_last=1.
  - Beat accepted, no new record in the same cycle: the next state is IDLE and out_valid drops to 0.
  - Beat accepted with simultaneous input accept: the new record loads. The next cycle shows out_idx=0 with the new tag, giving one record every NUM_FIELDS cycles at full throughput.
- in_data, in_tag and in_valid are ignored while in_ready=0.
- out_data = field out_idx of the shadow record, selected per MSB_FIRST. No arithmetic on the data; out_idx never exceeds NUM_FIELDS-1 (no wrap).

Optional Feature:
- Macro EDGE_FIELD_SERIALIZER_SKIP_ZERO_EN.
- Defined:
  - Fields equal to 0 are not emitted. out_idx still reports the true field index, so indices may jump.
  - out_last marks the last non-zero field.
  - An all-zero record emits exactly one beat: idx 0, data 0, out_last=1.
  - Skipping costs no extra cycles: the next non-zero index is computed combinationally from the shadow record.
- Undefined: every field is emitted in order, as described above.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0 and all outputs 0; after release, in_ready=1 and out_valid=0.
- Basic serialise (defaults, out_ready=1): in_data=64'h0011_2233_4455_6677, tag=4'h5 -> out_valid from cycle+1.
  - 8 beats: data 00,11,22,33,44,55,66,77; idx 0..7; tag 5; out_last only on idx 7.
- Backpressure: same record, out_ready low for 4 cycles on beat idx 2 -> out_data=8'h22 and idx=2 held stable; then 33..77 follow with no loss.
- Back-to-back: record A (tag 1) then record B (tag 2) offered continuously -> B's idx 0 beat appears the cycle after A's last beat; 16 beats in 16 cycles.
- Mid-record reset: assert rst_n=0 after beat idx 3 -> next cycle out_valid=0 and busy=0; a new record then starts at idx 0.
- Skip-zero (macro defined): in_data=64'h0000_AB00_0000_00CD -> beats (idx 2, AB) then (idx 7, CD, last); all-zero record -> single beat (idx 0, 00, last).
